// File: rtl/adder_domino_seq.sv
// Sequencer and round-robin two-port arbiter for a W-bit domino adder/subtractor.
// A granted request has its operands and Sub control registered towards the
// datapath. The sequencer then runs a precharge window with DP_Clk low and an
// evaluate window with DP_Clk high. At the end of evaluate it captures the sum
// and carry-out, and it pulses the winner's Ack for one cycle.
module adder_domino_seq #(
   parameter int W           = 8,
   parameter int PRE_CYCLES  = 1,   // legal 1..15
   parameter int EVAL_CYCLES = 2    // legal 1..15
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Req0,
   input  logic         Sub0,
   input  logic [W-1:0] A0,
   input  logic [W-1:0] B0,
   input  logic         Req1,
   input  logic         Sub1,
   input  logic [W-1:0] A1,
   input  logic [W-1:0] B1,
   output logic         Ack0,
   output logic         Ack1,
   output logic [W-1:0] Sum,
   output logic         Cout,
   output logic         Busy,
   output logic [W-1:0] DP_A,
   output logic [W-1:0] DP_B,
   output logic         DP_Sub,
   output logic         DP_Clk,
   input  logic [W-1:0] DP_Sum,
   input  logic         DP_Cout
);

   // Both window lengths fit a 4-bit down-counter.
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      EVAL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             gid;        // requester owning the operation in flight
   logic             rr_last;    // requester granted most recently
   logic             grant_vld;
   logic             grant_id;
   logic             grant_fire;
   logic             capture;

   // Round-robin arbitration: a lone requester wins; on a tie the requester
   // that did not win last time goes first.
   always_comb begin
      grant_vld = Req0 | Req1;
      grant_id  = 1'b0;
      if (Req0 && Req1) begin
         grant_id = ~rr_last;
      end else if (Req1) begin
         grant_id = 1'b1;
      end
   end

   // Next-state and window counter. Each window reloads cnt with its length
   // minus one and leaves the window when cnt reaches zero.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = PRE;
               cnt_nxt   = PRE_LOAD;
            end
         end
         PRE: begin
            if (cnt == '0) begin
               state_nxt = EVAL;
               cnt_nxt   = EVAL_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         EVAL: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign grant_fire = (state == IDLE) && grant_vld;
   assign capture    = (state == EVAL) && (cnt == '0);

   // State register and window counter.
   always_ff @(posedge Clk or posedge Rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (Rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Latch the winner's operands and identity on the grant edge. The operands
   // stay stable for the precharge and evaluate windows until the next grant.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         DP_A    <= '0;
         DP_B    <= '0;
         DP_Sub  <= 1'b0;
         gid     <= 1'b0;
         rr_last <= 1'b1;   // requester 0 wins the first tie after reset
      end else if (grant_fire) begin
         gid     <= grant_id;
         rr_last <= grant_id;
         if (grant_id) begin
            DP_A   <= A1;
            DP_B   <= B1;
            DP_Sub <= Sub1;
         end else begin
            DP_A   <= A0;
            DP_B   <= B0;
            DP_Sub <= Sub0;
         end
      end
   end

   // Capture the datapath result on the last evaluate cycle. It holds until
   // the next operation completes.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Sum  <= '0;
         Cout <= 1'b0;
      end else if (capture) begin
         Sum  <= DP_Sum;
         Cout <= DP_Cout;
      end
   end

   // Decode status outputs from the next state so that each is a clean flop
   // aligned with the state it describes. DP_Clk is high only in EVAL.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         DP_Clk <= 1'b0;
         Busy   <= 1'b0;
         Ack0   <= 1'b0;
         Ack1   <= 1'b0;
      end else begin
         DP_Clk <= (state_nxt == EVAL);
         Busy   <= (state_nxt != IDLE);
         Ack0   <= (state_nxt == DONE) && !gid;
         Ack1   <= (state_nxt == DONE) &&  gid;
      end
   end

endmodule

// File: tb/tb_adder_domino_seq.sv
// Bench for adder_domino_seq. A behavioural domino datapath drives a zero sum
// while precharging and returns the result while evaluating. Requester tasks
// queue their expected results, and an independent monitor checks each Ack
// against those queues and against the expected DP_Clk/Busy/Ack sequence.
module tb_adder_domino_seq;

   localparam int W  = 8;
   localparam int P  = 1;   // default PRE_CYCLES
   localparam int E  = 2;   // default EVAL_CYCLES
   localparam int P2 = 3;
   localparam int E2 = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
   } req_t;

   logic         Clk, Rst;
   logic         Req0, Sub0, Req1, Sub1;
   logic [W-1:0] A0, B0, A1, B1;
   logic         Ack0, Ack1, Cout, Busy, DP_Sub, DP_Clk, DP_Cout;
   logic [W-1:0] Sum, DP_A, DP_B, DP_Sum;

   // Second instance with longer windows.
   logic         Req0_b, Sub0_b, Req1_b, Sub1_b;
   logic [W-1:0] A0_b, B0_b, A1_b, B1_b;
   logic         Ack0_b, Ack1_b, Cout_b, Busy_b, DP_Sub_b, DP_Clk_b, DP_Cout_b;
   logic [W-1:0] Sum_b, DP_A_b, DP_B_b, DP_Sum_b;

   int   total = 0;
   int   bad   = 0;
   req_t q0[$];
   req_t q1[$];
   bit   pend[2];
   int   ack_order[$];

   adder_domino_seq #(.W(W), .PRE_CYCLES(P), .EVAL_CYCLES(E)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req0(Req0), .Sub0(Sub0), .A0(A0), .B0(B0),
      .Req1(Req1), .Sub1(Sub1), .A1(A1), .B1(B1),
      .Ack0(Ack0), .Ack1(Ack1), .Sum(Sum), .Cout(Cout), .Busy(Busy),
      .DP_A(DP_A), .DP_B(DP_B), .DP_Sub(DP_Sub), .DP_Clk(DP_Clk),
      .DP_Sum(DP_Sum), .DP_Cout(DP_Cout)
   );

   adder_domino_seq #(.W(W), .PRE_CYCLES(P2), .EVAL_CYCLES(E2)) dut_b (
      .Clk(Clk), .Rst(Rst),
      .Req0(Req0_b), .Sub0(Sub0_b), .A0(A0_b), .B0(B0_b),
      .Req1(Req1_b), .Sub1(Sub1_b), .A1(A1_b), .B1(B1_b),
      .Ack0(Ack0_b), .Ack1(Ack1_b), .Sum(Sum_b), .Cout(Cout_b), .Busy(Busy_b),
      .DP_A(DP_A_b), .DP_B(DP_B_b), .DP_Sub(DP_Sub_b), .DP_Clk(DP_Clk_b),
      .DP_Sum(DP_Sum_b), .DP_Cout(DP_Cout_b)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Behavioural domino datapaths: outputs discharge to 0 while precharging.
   always_comb begin
      {DP_Cout, DP_Sum} = '0;
      if (DP_Clk) {DP_Cout, DP_Sum} = {1'b0, DP_A} + {1'b0, DP_B ^ {W{DP_Sub}}} + 9'(DP_Sub);
   end

   always_comb begin
      {DP_Cout_b, DP_Sum_b} = '0;
      if (DP_Clk_b) {DP_Cout_b, DP_Sum_b} = {1'b0, DP_A_b} + {1'b0, DP_B_b ^ {W{DP_Sub_b}}} + 9'(DP_Sub_b);
   end

   // Reference result: plain add, or subtract with carry = "no borrow".
   function automatic logic [W:0] model(input req_t r);
      if (r.sub) return {r.a >= r.b, r.a - r.b};
      return {1'b0, r.a} + {1'b0, r.b};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One request: raise Req with operands, queue the expectation, hold until Ack.
   task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      req_t r;
      bit   got;
      int   budget;
      r.a = a; r.b = b; r.sub = sub;
      if (id == 0) begin
         A0 = a; B0 = b; Sub0 = sub; Req0 = 1'b1; q0.push_back(r);
      end else begin
         A1 = a; B1 = b; Sub1 = sub; Req1 = 1'b1; q1.push_back(r);
      end
      pend[id] = 1'b1;
      got = 1'b0;
      budget = 0;
      while (!got && budget < 200) begin
         @(posedge Clk); #1;
         got = (id == 0) ? Ack0 : Ack1;
         budget++;
      end
      check("ack_timeout", 32'(got), 32'd1);
      #1;
      if (id == 0) Req0 = 1'b0; else Req1 = 1'b0;
      pend[id] = 1'b0;
   endtask

   // Monitor: operation shape, operand hold, result scoreboard, fairness.
   initial begin
      int           idx;
      bit           in_op;
      bit           last_vld;
      int           last_id;
      bit           other_pend_last;
      int           id;
      logic [W-1:0] prev_a, prev_b;
      logic         prev_sub;
      req_t         r;
      logic [W:0]   exp_r;
      idx = 0; in_op = 0; last_vld = 0; last_id = 0; other_pend_last = 0;
      prev_a = '0; prev_b = '0; prev_sub = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if (Rst) begin
            in_op = 0; last_vld = 0;
            prev_a = '0; prev_b = '0; prev_sub = 1'b0;
            continue;
         end
         if (!(Busy && !in_op)) begin
            check("dp_a_hold", DP_A, prev_a);
            check("dp_b_hold", DP_B, prev_b);
            check("dp_sub_hold", DP_Sub, prev_sub);
         end
         prev_a = DP_A; prev_b = DP_B; prev_sub = DP_Sub;
         if (Busy) begin
            if (!in_op) begin in_op = 1; idx = 0; end
            check("dp_clk_phase", DP_Clk, 32'(idx >= P && idx < P + E));
            check("ack_timing", Ack0 | Ack1, 32'(idx == P + E));
            if (Ack0 | Ack1) begin
               check("ack_onehot", Ack0 & Ack1, 0);
               id = Ack1 ? 1 : 0;
               check("ack_expected", 32'((id == 0) ? q0.size() != 0 : q1.size() != 0), 1);
               if ((id == 0 && q0.size() != 0) || (id == 1 && q1.size() != 0)) begin
                  r = (id == 0) ? q0.pop_front() : q1.pop_front();
                  exp_r = model(r);
                  check("sum", Sum, exp_r[W-1:0]);
                  check("cout", Cout, exp_r[W]);
                  check("dp_a_op", DP_A, r.a);
                  check("dp_b_op", DP_B, r.b);
                  check("dp_sub_op", DP_Sub, r.sub);
               end
               if (last_vld) check("fairness", 32'(id == last_id && other_pend_last), 0);
               ack_order.push_back(id);
               last_id = id;
               other_pend_last = pend[1 - id];
               last_vld = 1;
            end
            idx++;
         end else begin
            if (in_op) begin
               check("busy_len", idx, P + E + 1);
               in_op = 0;
            end
            check("dp_clk_idle", DP_Clk, 0);
            check("ack_idle", Ack0 | Ack1, 0);
         end
      end
   end

   // Stimulus sequence.
   initial begin
      int n;
      Rst = 1'b1;
      Req0 = 0; Sub0 = 0; A0 = '0; B0 = '0;
      Req1 = 0; Sub1 = 0; A1 = '0; B1 = '0;
      Req0_b = 0; Sub0_b = 0; A0_b = '0; B0_b = '0;
      Req1_b = 0; Sub1_b = 0; A1_b = '0; B1_b = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_dp_clk", DP_Clk, 0);
      check("rst_busy", Busy, 0);
      check("rst_sum", Sum, 0);
      check("rst_ack", {Ack0, Ack1}, 0);
      check("rst_dp_a", DP_A, 0);
      check("rst_b_dp_clk", DP_Clk_b, 0);

      // Contention from reset: alternating grants starting with requester 0.
      n = ack_order.size();
      fork
         for (int i = 0; i < 4; i++) do_req(0, 8'($urandom), 8'($urandom), 1'($urandom));
         for (int i = 0; i < 4; i++) do_req(1, 8'($urandom), 8'($urandom), 1'($urandom));
         begin @(negedge Clk); Rst = 1'b0; end
      join
      check("contention_count", ack_order.size() - n, 8);
      for (int i = 0; i < 8; i++)
         if (n + i < ack_order.size()) check("contention_order", ack_order[n + i], i % 2);

      // Directed operations, including carry/borrow boundaries.
      do_req(0, 8'h3C, 8'h05, 1'b0);
      check("add_sum", Sum, 8'h41);
      check("add_cout", Cout, 0);
      do_req(1, 8'h05, 8'h07, 1'b1);
      check("sub_sum", Sum, 8'hFE);
      check("sub_cout", Cout, 0);
      do_req(0, 8'hFF, 8'h01, 1'b0);
      do_req(1, 8'h00, 8'h01, 1'b1);
      do_req(0, 8'h00, 8'h00, 1'b1);
      do_req(1, 8'hFF, 8'hFF, 1'b0);

      // Random traffic with random idle gaps on both requesters.
      fork
         for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            do_req(0, 8'($urandom), 8'($urandom), 1'($urandom));
         end
         for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            do_req(1, 8'($urandom), 8'($urandom), 1'($urandom));
         end
      join

      // Reset in the second evaluate cycle discards the operation.
      repeat (2) @(negedge Clk);
      A0 = 8'h77; B0 = 8'h11; Sub0 = 1'b0; Req0 = 1'b1;
      n = 0;
      do begin
         @(posedge Clk); #1;
         n++;
      end while (!DP_Clk && n < 20);
      check("eval_reached", DP_Clk, 1);
      @(posedge Clk); #3;
      Rst = 1'b1;
      #1;
      check("midrst_dp_clk", DP_Clk, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_sum", Sum, 0);
      check("midrst_cout", Cout, 0);
      check("midrst_ack", {Ack0, Ack1}, 0);
      check("midrst_dp_a", DP_A, 0);
      check("midrst_dp_sub", DP_Sub, 0);
      Req0 = 1'b0;
      n = ack_order.size();
      fork
         do_req(0, 8'h12, 8'h34, 1'b0);
         do_req(1, 8'h56, 8'h78, 1'b1);
         begin repeat (2) @(negedge Clk); Rst = 1'b0; end
      join
      check("post_rst_acks", ack_order.size() - n, 2);
      if (ack_order.size() > n) check("post_rst_first", ack_order[n], 0);

      // Longer windows: 3 precharge, 4 evaluate, Ack in the 8th cycle.
      @(negedge Clk);
      A0_b = 8'hA5; B0_b = 8'h5A; Sub0_b = 1'b0; Req0_b = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge Clk); #1;
         check("b_dp_clk", DP_Clk_b, 32'(c >= P2 && c < P2 + E2));
         check("b_busy", Busy_b, 32'(c <= P2 + E2));
         check("b_ack0", Ack0_b, 32'(c == P2 + E2));
         check("b_ack1", Ack1_b, 0);
         if (Ack0_b) Req0_b = 1'b0;
      end
      check("b_sum", Sum_b, 8'hFF);
      check("b_cout", Cout_b, 0);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
